ebi_master: RTL and testbench

Synthesizable EBI bus initiator that drives the 16-bit multiplexed address/data external bus interface from inside the FPGA. It converts a valid/ready request stream into ALE/CS/WE (and optionally RE) bus cycles. It is the transmitting end of the protocol that `ebi_interface` receives. It is used to drive the display RAM write path from on-chip sources and as an in-fabric stimulus generator in loopback builds.

---
 rtl/ebi_pkg.sv | 37 +++
 rtl/ebi_master.sv | 201 ++++++++++++++++++++
 tb/tb_ebi_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebi_pkg.sv
// ebi_pkg
//   Shared types and constants for the EBI initiator.
//   ebi_state_t : bus-cycle FSM states
//   ebi_cnt_t   : 8-bit phase down-counter
//   EBI_AW/DW   : address / data widths
//   *_IDLE      : inactive levels of the bus control strobes
//   phase_load(): converts a phase length parameter into a counter reload value.
//                 Lengths below 1 are treated as 1.
package ebi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_ALATCH  = 3'd2,
    ST_DSETUP  = 3'd3,
    ST_STROBE  = 3'd4,
    ST_DHOLD   = 3'd5
  } ebi_state_t;

  typedef logic [7:0] ebi_cnt_t;

  localparam int EBI_AW = 16;
  localparam int EBI_DW = 16;

  localparam logic CS_IDLE  = 1'b1;
  localparam logic WE_IDLE  = 1'b1;
  localparam logic RE_IDLE  = 1'b1;
  localparam logic ALE_IDLE = 1'b0;

  // The counter counts down to zero, so a phase of N cycles reloads with N-1.
  function automatic ebi_cnt_t phase_load(input int len);
    int clamped;
    clamped = (len < 1) ? 1 : ((len > 256) ? 256 : len);
    return ebi_cnt_t'(clamped - 1);
  endfunction

endpackage

// File: rtl/ebi_master.sv
// ebi_master
//   EBI bus initiator: turns a valid/ready request stream into multiplexed
//   ALE / CS / WE / RE bus cycles on a 16-bit AD bus.
//
// Configuration macro: EBI_MASTER_READ_EN
//   defined   - read transactions (req_we = 0) drive RE and return rsp_data.
//   undefined - every request is a write; EBI_RE = 1, rsp_valid/rsp_data = 0.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake
//   req_we/addr/data     : request contents, captured on acceptance
//   rsp_valid/rsp_data   : one-cycle read response
//   busy                 : high whenever the FSM is not idle
//   EBI_AD_O/OE/I        : AD bus output, drive enable, input
//   EBI_ALE              : address latch enable (active-high)
//   EBI_CS/WE/RE         : bus strobes (active-low)
//
// Handshake: a request is accepted on any rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and outside reset.
// The request fields are sampled on that edge and may change afterwards.
//
// Every output except req_ready is registered. The next output values are
// decoded from the next state, so each phase's levels appear on the first
// cycle of that phase.
module ebi_master
  import ebi_pkg::*;
#(
  parameter int ADDR_SETUP = 2,
  parameter int ADDR_HOLD  = 1,
  parameter int WR_SETUP   = 1,
  parameter int WR_STROBE  = 3,
  parameter int WR_HOLD    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [EBI_AW-1:0] req_addr,
  input  logic [EBI_DW-1:0] req_data,
  output logic              rsp_valid,
  output logic [EBI_DW-1:0] rsp_data,
  output logic              busy,
  output logic [EBI_DW-1:0] EBI_AD_O,
  output logic              EBI_AD_OE,
  input  logic [EBI_DW-1:0] EBI_AD_I,
  output logic              EBI_ALE,
  output logic              EBI_CS,
  output logic              EBI_WE,
  output logic              EBI_RE
);

  localparam ebi_cnt_t AS_L = phase_load(ADDR_SETUP);
  localparam ebi_cnt_t AH_L = phase_load(ADDR_HOLD);
  localparam ebi_cnt_t WS_L = phase_load(WR_SETUP);
  localparam ebi_cnt_t ST_L = phase_load(WR_STROBE);
  localparam ebi_cnt_t WH_L = phase_load(WR_HOLD);

  ebi_state_t        state, state_n;
  ebi_cnt_t          cnt, cnt_n;
  logic [EBI_AW-1:0] addr_q, addr_n;
  logic [EBI_DW-1:0] data_q, data_n;
  logic              we_q, we_n;

  logic [EBI_DW-1:0] ad_o_n;
  logic              ad_oe_n, ale_n, cs_n, we_o_n, busy_n;
  logic              re_n, rsp_valid_n;
  logic [EBI_DW-1:0] rsp_data_n;

  assign req_ready = (state == ST_IDLE) && !reset;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    data_n  = data_q;
    we_n    = we_q;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_n = ST_ADDR;
          cnt_n   = AS_L;
          addr_n  = req_addr;
          data_n  = req_data;
`ifdef EBI_MASTER_READ_EN
          we_n    = req_we;
`else
          we_n    = 1'b1;
`endif
        end
      end
      default: begin
        if (cnt != '0) begin
          cnt_n = cnt - 8'd1;
        end else begin
          case (state)
            ST_ADDR:   begin state_n = ST_ALATCH; cnt_n = AH_L; end
            ST_ALATCH: begin state_n = ST_DSETUP; cnt_n = WS_L; end
            ST_DSETUP: begin state_n = ST_STROBE; cnt_n = ST_L; end
            ST_STROBE: begin state_n = ST_DHOLD;  cnt_n = WH_L; end
            default:   begin state_n = ST_IDLE;   cnt_n = '0;   end
          endcase
        end
      end
    endcase
  end

  // Output decode from the next state. AD_O holds its last value whenever
  // the bus is not driven.
  always_comb begin
    ad_o_n      = EBI_AD_O;
    ad_oe_n     = 1'b0;
    ale_n       = ALE_IDLE;
    cs_n        = CS_IDLE;
    we_o_n      = WE_IDLE;
    re_n        = RE_IDLE;
    busy_n      = (state_n != ST_IDLE);
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data;
    case (state_n)
      ST_ADDR: begin
        ad_o_n  = addr_n;
        ad_oe_n = 1'b1;
        ale_n   = 1'b1;
      end
      ST_ALATCH: begin
        ad_o_n  = addr_n;
        ad_oe_n = 1'b1;
      end
      ST_DSETUP, ST_STROBE, ST_DHOLD: begin
        cs_n = 1'b0;
        if (we_n) begin
          ad_o_n  = data_n;
          ad_oe_n = 1'b1;
        end
        if (state_n == ST_STROBE) begin
          if (we_n) we_o_n = 1'b0;
          else      re_n   = 1'b0;
        end
      end
      default: ;
    endcase
    // Read data is sampled on the last STROBE cycle and presented on the
    // first DHOLD cycle.
    if (state == ST_STROBE && cnt == '0 && !we_q) begin
      rsp_valid_n = 1'b1;
      rsp_data_n  = EBI_AD_I;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b1;
      EBI_AD_O  <= '0;
      EBI_AD_OE <= 1'b0;
      EBI_ALE   <= ALE_IDLE;
      EBI_CS    <= CS_IDLE;
      EBI_WE    <= WE_IDLE;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      we_q      <= we_n;
      EBI_AD_O  <= ad_o_n;
      EBI_AD_OE <= ad_oe_n;
      EBI_ALE   <= ale_n;
      EBI_CS    <= cs_n;
      EBI_WE    <= we_o_n;
      busy      <= busy_n;
    end
  end

`ifdef EBI_MASTER_READ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      EBI_RE    <= RE_IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      EBI_RE    <= re_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
    end
  end
`else
  // Write-only build: read path tied off.
  logic unused_read_path;
  assign unused_read_path = ^{EBI_AD_I, req_we, re_n, rsp_valid_n, rsp_data_n};
  assign EBI_RE    = RE_IDLE;
  assign rsp_valid = 1'b0;
  assign rsp_data  = '0;
`endif

endmodule

// File: tb/tb_ebi_master.sv
// tb_ebi_master
//   Directed bench for ebi_master. Instance dut uses default phase lengths;
//   instance dut0 sets all five phase lengths to 0 (treated as 1).
module tb_ebi_master;

  logic        clk;
  logic        reset;

  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic [15:0] ad_o, ad_i;
  logic        ad_oe, ale, cs, we, re;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [15:0] z_req_addr, z_req_data;
  logic        z_rsp_valid;
  logic [15:0] z_rsp_data;
  logic        z_busy;
  logic [15:0] z_ad_o, z_ad_i;
  logic        z_ad_oe, z_ale, z_cs, z_we, z_re;

  int n_tests = 0;
  int n_fail  = 0;

  ebi_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .EBI_AD_O(ad_o), .EBI_AD_OE(ad_oe), .EBI_AD_I(ad_i),
    .EBI_ALE(ale), .EBI_CS(cs), .EBI_WE(we), .EBI_RE(re)
  );

  ebi_master #(
    .ADDR_SETUP(0), .ADDR_HOLD(0), .WR_SETUP(0), .WR_STROBE(0), .WR_HOLD(0)
  ) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_data(z_req_data),
    .rsp_valid(z_rsp_valid), .rsp_data(z_rsp_data), .busy(z_busy),
    .EBI_AD_O(z_ad_o), .EBI_AD_OE(z_ad_oe), .EBI_AD_I(z_ad_i),
    .EBI_ALE(z_ale), .EBI_CS(z_cs), .EBI_WE(z_we), .EBI_RE(z_re)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // advance one cycle and sample 1 ns after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_tests++; if (cs !== 1'b1 || we !== 1'b1 || re !== 1'b1 || ale !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: cs=%b we=%b re=%b ale=%b, need 1 1 1 0", cs, we, re, ale); end
    n_tests++; if (ad_oe !== 1'b0 || ad_o !== 16'h0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus: oe=%b ad=%h busy=%b, need 0 0000 0", ad_oe, ad_o, busy); end
    n_tests++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rsp: valid=%b data=%h, need 0 0000", rsp_valid, rsp_data); end
    n_tests++; if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b need 0", req_ready); end
    n_tests++; if (z_cs !== 1'b1 || z_we !== 1'b1 || z_ale !== 1'b0 || z_ad_oe !== 1'b0 || z_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut0: cs=%b we=%b ale=%b oe=%b busy=%b", z_cs, z_we, z_ale, z_ad_oe, z_busy); end
    reset = 1'b0;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b need 1", req_ready); end
    step();
  endtask

  // Default write: ADDR c0-c1, ALATCH c2, DSETUP c3, STROBE c4-c6, DHOLD c7, IDLE c8
  task automatic test_write();
    logic [8:0] ale_e, cs_e, we_e, oe_e, busy_e;
    logic [15:0] ad_e;
    int we_low;
    ale_e = 9'b000000011; cs_e = 9'b100000111; we_e = 9'b110001111;
    oe_e = 9'b011111111; busy_e = 9'b011111111;
    we_low = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0123; req_data = 16'hABCD;
    step();
    req_valid = 1'b0; req_addr = 16'hDEAD; req_data = 16'hBEEF;
    for (int i = 0; i < 9; i++) begin
      ad_e = (i < 3) ? 16'h0123 : 16'hABCD;
      if (we === 1'b0) we_low++;
      n_tests++; if (ale !== ale_e[i] || cs !== cs_e[i] || we !== we_e[i] || re !== 1'b1) begin
        n_fail++; $display("FAIL write_strobes c%0d: ale=%b cs=%b we=%b re=%b, need %b %b %b 1",
                           i, ale, cs, we, re, ale_e[i], cs_e[i], we_e[i]); end
      n_tests++; if (ad_oe !== oe_e[i] || ad_o !== ad_e || busy !== busy_e[i]) begin
        n_fail++; $display("FAIL write_bus c%0d: oe=%b ad=%h busy=%b, need %b %h %b",
                           i, ad_oe, ad_o, busy, oe_e[i], ad_e, busy_e[i]); end
      if (i < 8) step();
    end
    n_tests++; if (we_low !== 3) begin
      n_fail++; $display("FAIL write_we_len: got %0d cycles need 3", we_low); end
    step();
  endtask

`ifdef EBI_MASTER_READ_EN
  // Read: AD_OE drops at DSETUP, RE low c4-c6, sample in c6, rsp_valid in c7
  task automatic test_read();
    logic [8:0] oe_e, re_e, cs_e;
    int pulses;
    oe_e = 9'b000000111; re_e = 9'b110001111; cs_e = 9'b100000111;
    pulses = 0;
    ad_i = 16'h1111;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0042; req_data = 16'h9999;
    step();
    req_valid = 1'b0; req_we = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ad_i = (i == 6) ? 16'h5A5A : 16'h1111;
      if (rsp_valid === 1'b1) pulses++;
      n_tests++; if (ad_oe !== oe_e[i] || re !== re_e[i] || cs !== cs_e[i] || we !== 1'b1) begin
        n_fail++; $display("FAIL read_bus c%0d: oe=%b re=%b cs=%b we=%b, need %b %b %b 1",
                           i, ad_oe, re, cs, we, oe_e[i], re_e[i], cs_e[i]); end
      n_tests++; if (rsp_valid !== (i == 7) || rsp_data !== ((i >= 7) ? 16'h5A5A : 16'h0000)) begin
        n_fail++; $display("FAIL read_rsp c%0d: valid=%b data=%h", i, rsp_valid, rsp_data); end
      if (i < 8) step();
    end
    n_tests++; if (pulses !== 1) begin
      n_fail++; $display("FAIL read_pulses: got %0d need 1", pulses); end
    ad_i = 16'h0000;
    step();
  endtask
`else
  // Write-only build: a read request still runs as a write
  task automatic test_read_ignored();
    int we_low, re_low, rv;
    we_low = 0; re_low = 0; rv = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0200; req_data = 16'h3344;
    ad_i = 16'h5A5A;
    step();
    req_valid = 1'b0; req_we = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (we === 1'b0) we_low++;
      if (re === 1'b0) re_low++;
      if (rsp_valid === 1'b1) rv++;
      if (i == 5) begin
        n_tests++; if (ad_oe !== 1'b1 || ad_o !== 16'h3344) begin
          n_fail++; $display("FAIL noread_data: oe=%b ad=%h need 1 3344", ad_oe, ad_o); end
      end
      if (i < 8) step();
    end
    n_tests++; if (we_low !== 3) begin
      n_fail++; $display("FAIL noread_we: got %0d need 3", we_low); end
    n_tests++; if (re_low !== 0 || rv !== 0 || rsp_data !== 16'h0000) begin
      n_fail++; $display("FAIL noread_re_rsp: re_low=%0d rsp=%0d data=%h need 0 0 0000", re_low, rv, rsp_data); end
    ad_i = 16'h0000;
    step();
  endtask
`endif

  // Two queued writes: second acceptance 9 edges after the first
  task automatic test_back_to_back();
    int acc, busy_low;
    bit found;
    acc = -1; busy_low = 0; found = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h1000; req_data = 16'h0001;
    step();
    req_addr = 16'h2000; req_data = 16'h0002;
    for (int k = 0; k < 20 && !found; k++) begin
      if (busy === 1'b0) busy_low++;
      if (req_ready === 1'b1) begin acc = k + 1; found = 1'b1; end
      else step();
    end
    n_tests++; if (acc !== 9) begin
      n_fail++; $display("FAIL b2b_interval: got %0d need 9", acc); end
    n_tests++; if (busy_low !== 1 || cs !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap: idle=%0d cs=%b need 1 1", busy_low, cs); end
    step();
    req_valid = 1'b0;
    n_tests++; if (ale !== 1'b1 || ad_o !== 16'h2000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: ale=%b ad=%h busy=%b need 1 2000 1", ale, ad_o, busy); end
    repeat (9) step();
  endtask

  // Reset in the second STROBE cycle (c5) aborts the transaction
  task automatic test_reset_mid();
    int rv;
    rv = 0;
`ifdef EBI_MASTER_READ_EN
    req_we = 1'b0;
`else
    req_we = 1'b1;
`endif
    ad_i = 16'h7777;
    req_valid = 1'b1; req_addr = 16'h0777; req_data = 16'h0888;
    step();
    req_valid = 1'b0; req_we = 1'b1;
    repeat (5) step();
    n_tests++; if (cs !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre: cs=%b busy=%b need 0 1", cs, busy); end
    reset = 1'b1;
    step();
    n_tests++; if (cs !== 1'b1 || we !== 1'b1 || re !== 1'b1 || ale !== 1'b0) begin
      n_fail++; $display("FAIL abort_strobes: cs=%b we=%b re=%b ale=%b need 1 1 1 0", cs, we, re, ale); end
    n_tests++; if (ad_oe !== 1'b0 || ad_o !== 16'h0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_bus: oe=%b ad=%h busy=%b need 0 0000 0", ad_oe, ad_o, busy); end
    n_tests++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_rsp: valid=%b data=%h ready=%b need 0 0000 0", rsp_valid, rsp_data, req_ready); end
    step();
    reset = 1'b0;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_ready: got %b need 1", req_ready); end
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid === 1'b1 || cs !== 1'b1) rv++;
    end
    n_tests++; if (rv !== 0) begin
      n_fail++; $display("FAIL abort_quiet: %0d cycles with rsp_valid or cs low, need 0", rv); end
    ad_i = 16'h0000;
  endtask

  // All phases 0 -> 1 cycle each: 5 busy cycles, 6-edge repetition
  task automatic test_zero_params();
    int acc, busy_cnt, we_low, cs_low;
    bit found;
    acc = -1; busy_cnt = 0; we_low = 0; cs_low = 0; found = 1'b0;
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 16'h0AAA; z_req_data = 16'h0555;
    step();
    z_req_addr = 16'h0BBB; z_req_data = 16'h0666;
    n_tests++; if (z_ale !== 1'b1 || z_ad_o !== 16'h0AAA) begin
      n_fail++; $display("FAIL zero_addr: ale=%b ad=%h need 1 0aaa", z_ale, z_ad_o); end
    for (int k = 0; k < 20 && !found; k++) begin
      if (z_busy === 1'b1) busy_cnt++;
      if (z_we === 1'b0) we_low++;
      if (z_cs === 1'b0) cs_low++;
      if (z_we === 1'b0) begin
        n_tests++; if (z_ad_o !== 16'h0555 || z_ad_oe !== 1'b1) begin
          n_fail++; $display("FAIL zero_data: ad=%h oe=%b need 0555 1", z_ad_o, z_ad_oe); end
      end
      if (z_req_ready === 1'b1) begin acc = k + 1; found = 1'b1; end
      else step();
    end
    n_tests++; if (acc !== 6) begin
      n_fail++; $display("FAIL zero_interval: got %0d need 6", acc); end
    n_tests++; if (busy_cnt !== 5 || we_low !== 1 || cs_low !== 3) begin
      n_fail++; $display("FAIL zero_phases: busy=%0d we=%0d cs=%0d need 5 1 3", busy_cnt, we_low, cs_low); end
    step();
    z_req_valid = 1'b0;
    n_tests++; if (z_ale !== 1'b1 || z_ad_o !== 16'h0BBB) begin
      n_fail++; $display("FAIL zero_second: ale=%b ad=%h need 1 0bbb", z_ale, z_ad_o); end
    repeat (7) step();
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b1; req_addr = '0; req_data = '0; ad_i = '0;
    z_req_valid = 1'b0; z_req_we = 1'b1; z_req_addr = '0; z_req_data = '0; z_ad_i = '0;
    reset = 1'b1;
    #1;
    test_reset();
    test_write();
`ifdef EBI_MASTER_READ_EN
    test_read();
`else
    test_read_ignored();
`endif
    test_back_to_back();
    test_reset_mid();
    test_zero_params();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
